// File: rtl/sha_pkg.sv
// Shared constants and state encoding for the SHA-256 message padder.
package sha_pkg;

  localparam int unsigned SHA_WORD_W    = 32;
  localparam int unsigned SHA_BLK_WORDS = 16;
  localparam int unsigned SHA_LEN_IDX   = 14;
  localparam int unsigned WCNT_W        = 5;
  localparam logic [SHA_WORD_W-1:0] SHA_PAD_MARK = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    WAIT = 3'd2,
    PADZ = 3'd3,
    LENH = 3'd4,
    LENL = 3'd5
  } sha_state_e;

endpackage

// File: rtl/sha_pad_if.sv
// Message-stream and core-side signals of the SHA padder.
interface sha_pad_if
  import sha_pkg::*;
;
  logic                  msg_vld;
  logic                  msg_rdy;
  logic [SHA_WORD_W-1:0] msg_din;
  logic                  msg_last;
  logic [1:0]            msg_bytes;
  logic                  core_init;
  logic                  core_vld;
  logic [SHA_WORD_W-1:0] core_din;
  logic                  core_done;
  logic                  busy;
  logic                  msg_done;

  modport slave (
    input  msg_vld, msg_din, msg_last, msg_bytes, core_done,
    output msg_rdy, core_init, core_vld, core_din, busy, msg_done
  );

  modport master (
    output msg_vld, msg_din, msg_last, msg_bytes, core_done,
    input  msg_rdy, core_init, core_vld, core_din, busy, msg_done
  );
endinterface

// File: rtl/sha_pad.sv
// SHA-256 padder: streams message words to the core in 16-word blocks,
// appending the 0x80 marker, zero fill and 64-bit bit length.
module sha_pad
  import sha_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic      CLK_I,
  input  logic      RST_I,
  sha_pad_if.slave  bus
);

  localparam logic [WCNT_W-1:0] BLK_END = WCNT_W'(SHA_BLK_WORDS);
  localparam logic [WCNT_W-1:0] LEN_AT  = WCNT_W'(SHA_LEN_IDX);

  sha_state_e            state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [LEN_W-1:0]      bcnt_q, bcnt_d;
  logic                  last_q, last_d;
  logic                  mark_q, mark_d;
  logic                  lsent_q, lsent_d;
  logic                  msg_rdy_q, msg_rdy_d;
  logic                  core_init_q, core_init_d;
  logic                  core_vld_q, core_vld_d;
  logic [SHA_WORD_W-1:0] core_din_q, core_din_d;
  logic                  busy_q, busy_d;
  logic                  msg_done_q, msg_done_d;

  logic                  acc;
  logic [WCNT_W-1:0]     wnext;
  logic [LEN_W-1:0]      add_bytes;
  logic [63:0]           bit_len;

  // Final word: keep the valid bytes, place the marker right after them.
  function automatic logic [SHA_WORD_W-1:0] merge_last(input logic [SHA_WORD_W-1:0] d,
                                                       input logic [1:0] nb);
    logic [SHA_WORD_W-1:0] r;
    case (nb)
      2'd1:    r = {d[31:24], 8'h80, 16'h0000};
      2'd2:    r = {d[31:16], 8'h80, 8'h00};
      2'd3:    r = {d[31:8], 8'h80};
      default: r = d;
    endcase
    return r;
  endfunction

  assign acc       = bus.msg_vld & msg_rdy_q;
  assign wnext     = wcnt_q + WCNT_W'(1);
  assign add_bytes = (bus.msg_last && (bus.msg_bytes != 2'd0)) ? LEN_W'(bus.msg_bytes)
                                                               : LEN_W'(4);
  assign bit_len   = 64'(bcnt_q) << 3;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    bcnt_d      = bcnt_q;
    last_d      = last_q;
    mark_d      = mark_q;
    lsent_d     = lsent_q;
    core_init_d = 1'b0;
    core_vld_d  = 1'b0;
    core_din_d  = '0;
    msg_done_d  = 1'b0;

    case (state_q)
      IDLE, DATA: begin
        if (acc) begin
          core_init_d = (state_q == IDLE);
          core_vld_d  = 1'b1;
          core_din_d  = bus.msg_last ? merge_last(bus.msg_din, bus.msg_bytes) : bus.msg_din;
          bcnt_d      = ((state_q == IDLE) ? '0 : bcnt_q) + add_bytes;
          wcnt_d      = wnext;
          if (state_q == IDLE) begin
            lsent_d = 1'b0;
          end
          last_d = bus.msg_last;
          mark_d = bus.msg_last && (bus.msg_bytes == 2'd0);
          if (wnext == BLK_END) begin
            state_d = WAIT;
          end else if (!bus.msg_last) begin
            state_d = DATA;
          end else if ((bus.msg_bytes != 2'd0) && (wnext == LEN_AT)) begin
            state_d = LENH;
          end else begin
            state_d = PADZ;
          end
        end
      end
      // The core cannot finish in the cycle its 16th word is presented.
      WAIT: begin
        if (bus.core_done && !core_vld_q) begin
          wcnt_d = '0;
          if (lsent_q) begin
            msg_done_d = 1'b1;
            state_d    = IDLE;
          end else if (last_q) begin
            state_d = PADZ;
          end else begin
            state_d = DATA;
          end
        end
      end
      PADZ: begin
        core_vld_d = 1'b1;
        core_din_d = mark_q ? SHA_PAD_MARK : '0;
        mark_d     = 1'b0;
        wcnt_d     = wnext;
        if (wnext == BLK_END) begin
          state_d = WAIT;
        end else if (wnext == LEN_AT) begin
          state_d = LENH;
        end
      end
      LENH: begin
        core_vld_d = 1'b1;
        core_din_d = bit_len[63:32];
        wcnt_d     = wnext;
        state_d    = LENL;
      end
      LENL: begin
        core_vld_d = 1'b1;
        core_din_d = bit_len[31:0];
        wcnt_d     = wnext;
        lsent_d    = 1'b1;
        state_d    = WAIT;
      end
      default: state_d = IDLE;
    endcase

    msg_rdy_d = (state_d == IDLE) || ((state_d == DATA) && (wcnt_d != BLK_END));
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      last_q      <= 1'b0;
      mark_q      <= 1'b0;
      lsent_q     <= 1'b0;
      msg_rdy_q   <= 1'b0;
      core_init_q <= 1'b0;
      core_vld_q  <= 1'b0;
      core_din_q  <= '0;
      busy_q      <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      bcnt_q      <= bcnt_d;
      last_q      <= last_d;
      mark_q      <= mark_d;
      lsent_q     <= lsent_d;
      msg_rdy_q   <= msg_rdy_d;
      core_init_q <= core_init_d;
      core_vld_q  <= core_vld_d;
      core_din_q  <= core_din_d;
      busy_q      <= busy_d;
      msg_done_q  <= msg_done_d;
    end
  end

  assign bus.msg_rdy   = msg_rdy_q;
  assign bus.core_init = core_init_q;
  assign bus.core_vld  = core_vld_q;
  assign bus.core_din  = core_din_q;
  assign bus.busy      = busy_q;
  assign bus.msg_done  = msg_done_q;

endmodule

// File: tb/tb_sha_pad.sv
// Directed bench for sha_pad: short, 55/56/64-byte messages, stalls and reset.
module tb_sha_pad;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha_pad_if bus();

  sha_pad #(.LEN_W(32)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int init_cnt, init_idx, mdone_cnt, done_cyc, mdone_cyc, stall_cnt;
  int timeouts = 0;
  logic [31:0] cap[$];
  logic [31:0] exp_q[$];
  logic [31:0] data_w[16];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture everything the core sees, away from the active edge.
  always @(negedge clk) begin
    if (bus.core_init) begin
      init_cnt++;
      init_idx = cap.size();
    end
    if (bus.core_vld) cap.push_back(bus.core_din);
    if (bus.core_done) done_cyc = cyc;
    if (bus.msg_done) begin
      mdone_cnt++;
      mdone_cyc = cyc;
    end
    if (bus.msg_vld && !bus.msg_rdy) stall_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed cyc=%0d expected end", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s[%0d]", tag, i), (i < cap.size()) ? cap[i] : 32'hxxxx_xxxx, exp_q[i]);
    end
  endtask

  task automatic clr();
    cap.delete();
    exp_q.delete();
    init_cnt  = 0;
    init_idx  = -1;
    mdone_cnt = 0;
    done_cyc  = -100;
    mdone_cyc = -1;
    stall_cnt = 0;
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(32'h0);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int budget = 0;
    bus.msg_vld   = 1'b1;
    bus.msg_din   = d;
    bus.msg_last  = last;
    bus.msg_bytes = nb;
    while (!bus.msg_rdy && budget < 1000) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!bus.msg_rdy) timeouts++;
    @(posedge clk); #1;
    bus.msg_vld  = 1'b0;
    bus.msg_last = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int budget = 0;
    while (cap.size() < n && budget < 2000) begin
      @(posedge clk); #1;
      budget++;
    end
    if (cap.size() < n) timeouts++;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    bus.core_done = 1'b1;
    @(posedge clk); #1;
    bus.core_done = 1'b0;
  endtask

  task automatic respond(input int nblk, input bit stray);
    if (stray) begin
      wait_words(4);
      pulse_done();
    end
    for (int b = 0; b < nblk; b++) begin
      wait_words(16 * (b + 1));
      pulse_done();
    end
  endtask

  task automatic send_data(input int n, input logic [1:0] last_nb);
    for (int i = 0; i < n; i++) send_word(data_w[i], (i == n - 1), last_nb);
  endtask

  task automatic settle_and_check(input string tag, input int dones);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk_stream(tag);
    chk({tag, "_msg_done_cnt"}, 32'(mdone_cnt), 32'(dones));
    chk({tag, "_msg_done_lat"}, 32'(mdone_cyc), 32'(done_cyc + 1));
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      data_w[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
    bus.msg_vld   = 1'b0;
    bus.msg_din   = '0;
    bus.msg_last  = 1'b0;
    bus.msg_bytes = 2'd0;
    bus.core_done = 1'b0;
    clr();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_msg_rdy", 32'(bus.msg_rdy), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_core_vld", 32'(bus.core_vld), 32'd0);
    chk("rst_core_init", 32'(bus.core_init), 32'd0);
    chk("rst_msg_done", 32'(bus.msg_done), 32'd0);
    chk("rst_core_din", bus.core_din, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_msg_rdy", 32'(bus.msg_rdy), 32'd1);

    // "abc"
    clr();
    fork
      send_word(32'h6162_6300, 1'b1, 2'd3);
      respond(1, 1'b0);
    join
    exp_q.push_back(32'h6162_6380);
    push_zeros(14);
    exp_q.push_back(32'h0000_0018);
    settle_and_check("abc", 1);
    chk("abc_init_cnt", 32'(init_cnt), 32'd1);
    chk("abc_init_idx", 32'(init_idx), 32'd0);

    // 55 bytes: marker merged into word 13, length fits in the same block
    clr();
    fork
      send_data(14, 2'd3);
      respond(1, 1'b0);
    join
    for (int i = 0; i < 13; i++) exp_q.push_back(data_w[i]);
    exp_q.push_back(32'h3435_3680);
    push_zeros(1);
    exp_q.push_back(32'h0000_01B8);
    settle_and_check("m55", 1);

    // 56 bytes: marker at word 14 forces a second block
    clr();
    fork
      send_data(14, 2'd0);
      respond(2, 1'b0);
    join
    for (int i = 0; i < 14; i++) exp_q.push_back(data_w[i]);
    exp_q.push_back(32'h8000_0000);
    push_zeros(1);
    push_zeros(15);
    exp_q.push_back(32'h0000_01C0);
    settle_and_check("m56", 1);

    // 64 bytes then "abc" held on the bus throughout, stray core_done in DATA
    clr();
    fork
      begin
        send_data(16, 2'd0);
        send_word(32'h6162_6300, 1'b1, 2'd3);
      end
      respond(3, 1'b1);
    join
    for (int i = 0; i < 16; i++) exp_q.push_back(data_w[i]);
    exp_q.push_back(32'h8000_0000);
    push_zeros(14);
    exp_q.push_back(32'h0000_0200);
    exp_q.push_back(32'h6162_6380);
    push_zeros(14);
    exp_q.push_back(32'h0000_0018);
    settle_and_check("m64_abc", 2);
    chk("m64_init_cnt", 32'(init_cnt), 32'd2);
    chk("m64_init_idx", 32'(init_idx), 32'd32);
    chk("m64_stalled", 32'(stall_cnt > 0), 32'd1);

    // Reset after 7 core words, then a clean restart
    clr();
    for (int i = 0; i < 7; i++) send_word(data_w[i], 1'b0, 2'd0);
    @(negedge clk); #1;
    chk("mid_words", 32'(cap.size()), 32'd7);
    chk("mid_core_vld", 32'(bus.core_vld), 32'd1);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_core_vld", 32'(bus.core_vld), 32'd0);
    chk("mrst_core_din", bus.core_din, 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_msg_rdy", 32'(bus.msg_rdy), 32'd0);
    chk("mrst_core_init", 32'(bus.core_init), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_idle_rdy", 32'(bus.msg_rdy), 32'd1);
    clr();
    fork
      send_word(32'h6162_6300, 1'b1, 2'd3);
      respond(1, 1'b0);
    join
    exp_q.push_back(32'h6162_6380);
    push_zeros(14);
    exp_q.push_back(32'h0000_0018);
    settle_and_check("post_rst", 1);
    chk("post_rst_init_idx", 32'(init_idx), 32'd0);

    chk("timeouts", 32'(timeouts), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha_pad.md
Name: sha_pad

Overview:
- Upstream feeder for the SHA wishbone peripheral's core.
- Accepts a raw message as a stream of big-endian 32-bit words and applies SHA-256 padding (0x80 marker, zero fill, 64-bit bit-length).
- Emits exactly 16 words per 512-bit block on the core's init/vld/din interface.
- Waits for the core's done pulse between blocks.

Parameters:
- LEN_W, 32, width of the message byte counter; messages up to 2^LEN_W-1 bytes.

Ports:
- CLK_I  input  1  system clock
- RST_I  input  1  reset; asynchronous, active-high
- msg_vld  input  1  message word valid
- msg_rdy  output  1  block can accept a message word this cycle
- msg_din  input  32  message word; byte0 = bits[31:24]
- msg_last  input  1  final word of the message
- msg_bytes  input  2  valid bytes in the final word: 1..3, 0 = 4; ignored unless msg_last
- core_init  output  1  one-cycle pulse; restarts core chaining at message start
- core_vld  output  1  one-cycle word strobe to the core
- core_din  output  32  word to the core
- core_done  input  1  core finished the current 512-bit block
- busy  output  1  message in progress (not IDLE)
- msg_done  output  1  one-cycle pulse when the last block's core_done arrives

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter and byte counter 0.
- All outputs are registered.
- Transfer rule: a word is accepted when msg_vld & msg_rdy.
- msg_rdy = 1 in IDLE and in DATA while wcnt < 16. It is 0 in every other state.
- One core word per cycle maximum.
- States:
  - IDLE: accepting a word pulses core_init in that cycle, then goes to DATA.
  - DATA: each accepted word drives core_vld/core_din on the next cycle (latency 1).
  - WAIT: waits for core_done after the 16th word of a block.
  - PADZ: emits 0x80 and/or zero words.
  - LENH: emits the length high word.
  - LENL: emits the length low word.
- Counters:
  - wcnt (4 bits + wrap flag) counts core words in the current block and clears on entering a new block.
  - bcnt (LEN_W bits) adds 4 per non-last word and k per last word (k = 1..4).
  - bcnt wraps silently on overflow; there is no error flag.
- Last-word merge, with k = valid bytes:
  - k<4: emitted word = data bytes [0..k-1], 0x80 at byte k, zeros below.
  - k=4: emitted word is the data word unchanged; the marker word 0x80000000 follows as a separate PADZ word.
- After the marker, zero words fill up to wcnt = 14; then LENH, then LENL.
- If the marker lands at word index 14 or 15:
  - Zero-fill to 16 and enter WAIT.
  - The next block is 14 zero words, then LENH, then LENL.
- Length words:
  - bit length = {bcnt, 3'b000}, zero-extended to 64 bits.
  - LENH = bits[63:32]; LENL = bits[31:0].
- After the 16th word of any block, go to WAIT. On core_done:
  - If more words remain (data or padding), clear wcnt and resume DATA or PADZ.
  - If LENL was sent, pulse msg_done and go to IDLE.
- In DATA, a word arriving at wcnt = 16 is not possible because msg_rdy is already low.
- The core is never sent a 17th word before core_done.
- core_done outside WAIT is ignored. core_done in the same cycle the 16th word is emitted is ignored; the core cannot finish that fast.
- msg_vld held high in WAIT, PADZ, LENH or LENL: stalls, nothing is lost.
- Words after msg_last are not accepted until IDLE.
- msg_last on the very first word is legal (single-word message).
- Zero-length messages are not supported.
- Reset mid-operation: immediate return to IDLE. Any partial block sent to the core is abandoned; the next message's core_init restarts the core.

Decomposition:
- Shared package sha_pkg:
  - constant SHA_BLK_WORDS = 16
  - constant SHA_LEN_IDX = 14
  - constant SHA_PAD_MARK = 32'h80000000
  - state encoding: IDLE, DATA, WAIT, PADZ, LENH, LENL
- Last-word merge is a small combinational function inside the module. No sub-module is needed.

Test Plan:
- "abc": 0x61626300, last, bytes=3 -> init pulse; words 0x61626380, 14×0x00000000, 0x00000018; msg_done one cycle after core_done.
- 55-byte message (14 words, last bytes=3) -> single block; word 13 = data|0x80 at byte 3; word 14 = 0; word 15 = 0x000001B8.
- 56-byte message (14 full words) -> block 1: 14 data words, 0x80000000, 0x00000000.
  - Wait for core_done.
  - Block 2: 14 zeros, 0x00000000, 0x000001C0.
- 64-byte message (16 full words) -> block 1 is data only; WAIT. Block 2: 0x80000000, 13 zeros, 0x00000000, 0x00000200.
- Back-to-back / stall: hold msg_vld high during WAIT and PADZ -> msg_rdy stays 0, no core_vld. Words resume exactly in order; a stray core_done in DATA has no effect.
- Reset mid-block: assert RST_I after 7 core words -> all outputs 0 immediately, busy=0. The next message starts with core_init and wcnt=0.
